// File: rtl/mc10_exp_bus.sv
// MC-10 multi-slot expansion-bus controller: decoded slot windows, sequenced
// select/strobe/acknowledge access with wait states, timeout and latched NMI.
module mc10_exp_bus #(
    parameter int NUM_SLOTS = 4,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 16,
    parameter int WIN_BITS  = 10,
    parameter logic [ADDR_W-WIN_BITS-1:0] BASE_PAGE = 'h20,
    parameter int TIMEOUT   = 15
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic                        cpu_req,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic                        cpu_rw,
    input  logic [DATA_W-1:0]           cpu_dout,
    output logic [DATA_W-1:0]           cpu_din,
    output logic                        cpu_ready,
    output logic                        busy,
    output logic [NUM_SLOTS-1:0]        exp_sel,
    output logic [ADDR_W-1:0]           exp_addr,
    output logic [DATA_W-1:0]           exp_dout,
    output logic                        exp_rw,
    output logic                        exp_strobe,
    input  logic [NUM_SLOTS*DATA_W-1:0] exp_din,
    input  logic [NUM_SLOTS-1:0]        exp_ack,
    input  logic [NUM_SLOTS-1:0]        exp_nmi,
    input  logic [NUM_SLOTS-1:0]        nmi_clr,
    output logic                        nmi,
    output logic [NUM_SLOTS-1:0]        nmi_pend,
    output logic                        bus_err,
    input  logic                        err_clr
);

    localparam int PW = ADDR_W - WIN_BITS;
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  rw_q, rw_d;
    logic [DATA_W-1:0]     dout_q, dout_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  bus_err_q, bus_err_d;
    logic [NUM_SLOTS-1:0]  nmi_pend_q, nmi_pend_d;
    logic [NUM_SLOTS-1:0]  nmi_prev_q, nmi_prev_d;
    logic                  nmi_q, nmi_d;

    logic [PW-1:0]         page_off;
    logic                  hit;
    logic                  ack_sel;
    logic [DATA_W-1:0]     din_sel;
    logic                  timeout_hit;

    // Unsigned subtraction makes pages below BASE_PAGE wrap to large values and miss.
    always_comb begin
        page_off = cpu_addr[ADDR_W-1:WIN_BITS] - BASE_PAGE;
        hit      = (page_off < PW'(NUM_SLOTS));
        ack_sel  = exp_ack[int'(slot_q)];
        din_sel  = exp_din[int'(slot_q)*DATA_W +: DATA_W];
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        dout_d      = dout_q;
        slot_d      = slot_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        timeout_hit = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (hit) begin
                        addr_d  = cpu_addr;
                        rw_d    = cpu_rw;
                        dout_d  = cpu_dout;
                        slot_d  = page_off[SW-1:0];
                        state_d = SETUP;
                    end else begin
                        data_d  = '0;
                        state_d = DONE;
                    end
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = STROBE;
            end
            STROBE: begin
                if (ack_sel) begin
                    data_d  = rw_q ? din_sel : '0;
                    state_d = DONE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    data_d      = '0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A timeout in the same cycle as err_clr wins.
        bus_err_d  = timeout_hit ? 1'b1 : (err_clr ? 1'b0 : bus_err_q);
        nmi_prev_d = exp_nmi;
        nmi_pend_d = (nmi_pend_q & ~nmi_clr) | (exp_nmi & ~nmi_prev_q);
        nmi_d      = |nmi_pend_d;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rw_q       <= 1'b1;
            dout_q     <= '0;
            slot_q     <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            bus_err_q  <= 1'b0;
            nmi_pend_q <= '0;
            nmi_prev_q <= '0;
            nmi_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            dout_q     <= dout_d;
            slot_q     <= slot_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            bus_err_q  <= bus_err_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_prev_q <= nmi_prev_d;
            nmi_q      <= nmi_d;
        end
    end

    // Outputs decode straight from flops, so an asynchronous reset clears them at once.
    always_comb begin
        busy       = (state_q != IDLE);
        cpu_ready  = (state_q == DONE);
        cpu_din    = (state_q == DONE) ? data_q : '0;
        exp_sel    = ((state_q == SETUP) || (state_q == STROBE)) ?
                     (NUM_SLOTS'(1) << slot_q) : '0;
        exp_strobe = (state_q == STROBE);
        exp_rw     = ((state_q == SETUP) || (state_q == STROBE)) ? rw_q : 1'b1;
        exp_addr   = addr_q;
        exp_dout   = dout_q;
        nmi        = nmi_q;
        nmi_pend   = nmi_pend_q;
        bus_err    = bus_err_q;
    end

endmodule

// File: tb/tb_mc10_exp_bus.sv
// Self-checking bench for mc10_exp_bus: directed scenarios plus randomized
// accesses checked against a latency/decode reference model.
module tb_mc10_exp_bus;

    localparam int NS = 4;
    localparam int TO = 15;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_ready;
    logic        busy;
    logic [3:0]  exp_sel;
    logic [15:0] exp_addr;
    logic [7:0]  exp_dout;
    logic        exp_rw;
    logic        exp_strobe;
    logic [31:0] exp_din;
    logic [3:0]  exp_ack;
    logic [3:0]  exp_nmi;
    logic [3:0]  nmi_clr;
    logic        nmi;
    logic [3:0]  nmi_pend;
    logic        bus_err;
    logic        err_clr;

    int   total = 0;
    int   bad = 0;
    int   ready_cnt = 0;
    logic exp_err = 1'b0;

    mc10_exp_bus dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_rw     (cpu_rw),
        .cpu_dout   (cpu_dout),
        .cpu_din    (cpu_din),
        .cpu_ready  (cpu_ready),
        .busy       (busy),
        .exp_sel    (exp_sel),
        .exp_addr   (exp_addr),
        .exp_dout   (exp_dout),
        .exp_rw     (exp_rw),
        .exp_strobe (exp_strobe),
        .exp_din    (exp_din),
        .exp_ack    (exp_ack),
        .exp_nmi    (exp_nmi),
        .nmi_clr    (nmi_clr),
        .nmi        (nmi),
        .nmi_pend   (nmi_pend),
        .bus_err    (bus_err),
        .err_clr    (err_clr)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) if (cpu_ready === 1'b1) ready_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Reference: 1 KB windows, slot i at page 32+i; latency from the access rules.
    function automatic void model(input logic [15:0] addr, input int delay,
                                  output bit hit, output int slot, output int lat, output bit tmo);
        int page;
        page = int'(addr) / 1024;
        hit  = (page >= 32) && (page < 32 + NS);
        slot = hit ? page - 32 : 0;
        tmo  = hit && (delay >= TO);
        lat  = !hit ? 1 : (tmo ? 2 + TO : 3 + delay);
    endfunction

    task automatic run_access(input logic [15:0] addr, input logic rw, input logic [7:0] wdata,
                              input int delay, input logic [31:0] din_all,
                              input bit hold_clr, input bit spam);
        bit         hit, tmo;
        int         slot, lat;
        logic [3:0] oh;
        logic [7:0] rd_exp;
        model(addr, delay, hit, slot, lat, tmo);
        oh     = hit ? (4'b0001 << slot) : 4'b0000;
        rd_exp = (hit && rw && !tmo) ? din_all[slot*8 +: 8] : 8'h00;
        exp_din  = din_all;
        cpu_req  = 1'b1;
        cpu_addr = addr;
        cpu_rw   = rw;
        cpu_dout = wdata;
        err_clr  = hold_clr;
        exp_ack  = 4'($urandom);
        for (int c = 1; c <= lat; c++) begin
            tick();
            cpu_req  = spam && (c < lat);
            cpu_addr = 16'($urandom);
            cpu_rw   = 1'($urandom);
            cpu_dout = 8'($urandom);
            if (c < lat) begin
                check($sformatf("busy_c%0d", c), busy, 1'b1);
                check($sformatf("ready_early_c%0d", c), cpu_ready, 1'b0);
                check($sformatf("sel_c%0d", c), exp_sel, oh);
                check($sformatf("strobe_c%0d", c), exp_strobe, hit && (c >= 2));
                if (hit) begin
                    check($sformatf("exp_addr_c%0d", c), exp_addr, addr);
                    check($sformatf("exp_rw_c%0d", c), exp_rw, rw);
                    check($sformatf("exp_dout_c%0d", c), exp_dout, wdata);
                end
                exp_ack = 4'($urandom);
                if (hit && c >= 2) exp_ack[slot] = (c - 2 >= delay);
            end else begin
                err_clr = 1'b0;
                exp_err = tmo ? 1'b1 : (hold_clr ? 1'b0 : exp_err);
                check("ready_done", cpu_ready, 1'b1);
                check("din_done", cpu_din, rd_exp);
                check("sel_done", exp_sel, 4'b0000);
                check("strobe_done", exp_strobe, 1'b0);
                check("rw_done", exp_rw, 1'b1);
                check("bus_err_done", bus_err, exp_err);
            end
        end
        tick();
        check("ready_after", cpu_ready, 1'b0);
        check("busy_after", busy, 1'b0);
        check("din_after", cpu_din, 8'h00);
        check("bus_err_after", bus_err, exp_err);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        exp_err = 1'b0;
        check("err_clr", bus_err, 1'b0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_busy"}, busy, 1'b0);
        check({pfx, "_ready"}, cpu_ready, 1'b0);
        check({pfx, "_din"}, cpu_din, 8'h00);
        check({pfx, "_sel"}, exp_sel, 4'b0000);
        check({pfx, "_strobe"}, exp_strobe, 1'b0);
        check({pfx, "_rw"}, exp_rw, 1'b1);
        check({pfx, "_addr"}, exp_addr, 16'h0000);
        check({pfx, "_dout"}, exp_dout, 8'h00);
        check({pfx, "_pend"}, nmi_pend, 4'b0000);
        check({pfx, "_nmi"}, nmi, 1'b0);
        check({pfx, "_err"}, bus_err, 1'b0);
    endtask

    initial begin
        int base;
        reset    = 1'b1;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        cpu_rw   = 1'b1;
        cpu_dout = '0;
        exp_din  = '0;
        exp_ack  = '0;
        exp_nmi  = '0;
        nmi_clr  = '0;
        err_clr  = 1'b0;
        #12;
        check_reset_outputs("por");
        @(negedge clk_sys);
        reset = 1'b0;
        tick();

        // Read slot 1, zero wait; write slot 3, two wait states.
        run_access(16'h8400, 1'b1, 8'h00, 0, 32'h1122_A533, 1'b0, 1'b0);
        run_access(16'h8C10, 1'b0, 8'h3C, 2, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Timeout, clear, then timeout coincident with err_clr.
        run_access(16'h8000, 1'b1, 8'h00, 1000, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick();
        check("bus_err_sticky", bus_err, 1'b1);
        clear_err();
        run_access(16'h8000, 1'b1, 8'h00, 1000, 32'hDEAD_BEEF, 1'b1, 1'b0);
        clear_err();

        // Misses just below and just above the slot windows.
        run_access(16'h7FFF, 1'b1, 8'h00, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_access(16'h9000, 1'b1, 8'h00, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // NMI edge latch, clear without re-set while held, fresh edge.
        exp_nmi = 4'b0100;
        tick();
        check("nmi_pend_set", nmi_pend, 4'b0100);
        check("nmi_set", nmi, 1'b1);
        nmi_clr = 4'b0100;
        tick();
        nmi_clr = 4'b0000;
        check("nmi_pend_clr", nmi_pend, 4'b0000);
        check("nmi_clr", nmi, 1'b0);
        repeat (3) tick();
        check("nmi_pend_held", nmi_pend, 4'b0000);
        exp_nmi = 4'b0000;
        tick();
        exp_nmi = 4'b0100;
        tick();
        check("nmi_pend_reedge", nmi_pend, 4'b0100);
        exp_nmi = 4'b0110;
        nmi_clr = 4'b0010;
        tick();
        nmi_clr = 4'b0000;
        check("nmi_pend_set_wins", nmi_pend, 4'b0110);
        nmi_clr = 4'b0110;
        tick();
        nmi_clr = 4'b0000;
        exp_nmi = 4'b0000;
        check("nmi_pend_clr_all", nmi_pend, 4'b0000);
        check("nmi_clr_all", nmi, 1'b0);
        tick();

        // Randomized accesses, including back-to-back requests and near-timeout waits.
        for (int i = 0; i < 60; i++) begin
            logic [15:0] a;
            int          d;
            a = {6'(30 + $urandom_range(0, 7)), 10'($urandom)};
            d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 16)) : int'($urandom_range(0, 4));
            run_access(a, 1'($urandom), 8'($urandom), d, $urandom, 1'b0, 1'b0);
            if (exp_err && $urandom_range(0, 1) == 1) clear_err();
            repeat ($urandom_range(0, 2)) tick();
        end

        // Leave an NMI pending so the reset has something to clear.
        exp_nmi = 4'b1000;
        tick();
        exp_nmi = 4'b0000;
        check("nmi_pend_pre_reset", nmi_pend, 4'b1000);

        // Reset asserted mid-STROBE.
        exp_ack  = 4'b0000;
        cpu_req  = 1'b1;
        cpu_addr = 16'h8400;
        cpu_rw   = 1'b1;
        tick();
        cpu_req = 1'b0;
        tick();
        check("strobe_pre_reset", exp_strobe, 1'b1);
        base = ready_cnt;
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async");
        @(posedge clk_sys);
        #1;
        check("busy_in_reset", busy, 1'b0);
        @(negedge clk_sys);
        reset   = 1'b0;
        exp_err = 1'b0;
        tick();
        check("no_ready_on_reset", ready_cnt - base, 0);

        // Access after release with requests thrown at it while busy.
        base = ready_cnt;
        run_access(16'h8400, 1'b1, 8'h00, 3, 32'h0000_5A00, 1'b0, 1'b1);
        repeat (3) tick();
        check("ready_count_spam", ready_cnt - base, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc10_exp_bus.md
Name: mc10_exp_bus

Overview:
- Multi-slot expansion-bus controller for the MC-10 family core.
- Replaces the single `exp_sel` / OR-ed `exp_din` connector with NUM_SLOTS decoded windows.
- Runs a sequenced select/strobe/acknowledge cycle per access, with wait states, a timeout, and latched per-slot NMI.
- Sits between the CPU data-bus mux and the external peripheral models; its read data is OR-ed into the CPU data bus.

Parameters:
- NUM_SLOTS, 4, number of expansion slots (1..8).
- DATA_W, 8, data width.
- ADDR_W, 16, address width.
- WIN_BITS, 10, log2 window size per slot (1 KB).
- BASE_PAGE, 6'h20, `cpu_addr[ADDR_W-1:WIN_BITS]` value of slot 0; slot i = BASE_PAGE+i.
- TIMEOUT, 15, max STROBE cycles before forced completion (1..255).

Ports:
- clk_sys  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  one-cycle access request; sampled only in IDLE.
- cpu_addr  in  ADDR_W  access address, captured on accepted req.
- cpu_rw  in  1  1=read, 0=write, captured with address.
- cpu_dout  in  DATA_W  write data, captured with address.
- cpu_din  out  DATA_W  read data; 0 except in the DONE cycle of a mapped read.
- cpu_ready  out  1  one-cycle completion pulse.
- busy  out  1  high in any state but IDLE.
- exp_sel  out  NUM_SLOTS  one-hot slot select.
- exp_addr  out  ADDR_W  latched address.
- exp_dout  out  DATA_W  latched write data.
- exp_rw  out  1  latched direction; 1 when idle.
- exp_strobe  out  1  data strobe, high in STROBE.
- exp_din  in  NUM_SLOTS*DATA_W  per-slot read data, slot i at [i*DATA_W +: DATA_W].
- exp_ack  in  NUM_SLOTS  per-slot ready; sampled only in STROBE for the selected slot.
- exp_nmi  in  NUM_SLOTS  per-slot NMI request, level.
- nmi_clr  in  NUM_SLOTS  one-cycle clear of latched NMI bits.
- nmi  out  1  OR of latched NMI bits.
- nmi_pend  out  NUM_SLOTS  latched NMI bits.
- bus_err  out  1  sticky timeout flag.
- err_clr  in  1  clears bus_err.

Behaviour:
- Reset values:
  - state = IDLE; busy = 0; cpu_ready = 0; cpu_din = 0.
  - exp_sel = 0; exp_strobe = 0; exp_rw = 1; exp_addr = 0; exp_dout = 0.
  - nmi_pend = 0; nmi = 0; bus_err = 0.
  - NMI edge-detect history = 0.
- Reset mid-access aborts immediately; no ready pulse is produced.
- Decode: hit when `cpu_addr[ADDR_W-1:WIN_BITS] - BASE_PAGE < NUM_SLOTS`, computed as unsigned with width ADDR_W-WIN_BITS. No wrap: pages below BASE_PAGE miss.
- FSM states: IDLE, SETUP, STROBE, DONE.
  - IDLE, cpu_req=1 and hit: latch addr/rw/dout and slot index, go to SETUP.
  - IDLE, cpu_req=1 and miss: go to DONE with the miss flag set. No exp_sel and no strobe are issued.
  - SETUP (exactly 1 cycle): exp_sel one-hot and exp_addr/exp_rw/exp_dout valid; exp_strobe = 0; go to STROBE, wait counter = 0.
  - STROBE: exp_sel and exp_strobe high.
    - If exp_ack[slot]=1, capture exp_din[slot] if reading, then go to DONE.
    - Else if counter == TIMEOUT-1, set bus_err, capture 0, go to DONE.
    - Else counter+1.
  - DONE (1 cycle):
    - cpu_ready = 1; exp_sel = 0; exp_strobe = 0; exp_rw returns to 1.
    - cpu_din = captured data for a mapped read; 0 for writes, misses and timeouts.
    - Next state IDLE.
- Latency:
  - Hit with ack already high: req at cycle N gives cpu_ready at N+3.
  - Each missing-ack cycle adds 1.
  - Timeout: ready at N+2+TIMEOUT.
  - Miss: ready at N+1.
- cpu_req while busy is ignored (not queued). Back-to-back: a req in the cycle after DONE (IDLE) is accepted.
- exp_ack of unselected slots is ignored.
- NMI:
  - nmi_pend[i] sets on a rising edge of exp_nmi[i] (registered previous value).
  - nmi_clr[i] clears it; a set and clear in the same cycle leaves it set.
  - A held-high exp_nmi does not re-set after a clear.
  - nmi is registered, so it follows nmi_pend with no extra cycle.
- bus_err: a set (timeout) takes priority over err_clr in the same cycle.

Test Plan:
- Read, slot 1, zero wait: addr 16'h8400, exp_ack[1]=1, exp_din slot1 = 8'hA5, req at cycle 0.
  - Required: exp_sel = 4'b0010 during cycles 1-2; exp_strobe high in cycle 2 only.
  - Required: cpu_ready and cpu_din = 8'hA5 in cycle 3, 8'h00 in cycle 4.
- Write, slot 3, 2 wait states: addr 16'h8C10, dout 8'h3C, ack raised 2 cycles into STROBE.
  - Required: exp_rw = 0 and exp_dout = 8'h3C throughout; ready at cycle 5; cpu_din = 0.
- Timeout, TIMEOUT=15, no ack, addr 16'h8000.
  - Required: ready at cycle 17; bus_err = 1 and remains 1.
  - Required: err_clr clears it; err_clr coincident with a second timeout keeps it at 1.
- Miss, addr 16'h7FFF and addr 16'h9000.
  - Required: ready at cycle 1; exp_sel never nonzero; cpu_din = 0.
- NMI: exp_nmi[2] rises and stays high.
  - Required: nmi_pend = 4'b0100 and nmi = 1.
  - Required: nmi_clr[2] clears to 0 with no re-set while the input is held; a fresh edge sets it again.
- Reset asserted in STROBE.
  - Required: outputs return to reset values asynchronously, no cpu_ready.
  - Required: a req after release completes normally. A req during busy is ignored (ready count = 1).
